ll_step_engine: RTL and testbench

//  Lunar-lander state engine: memory, digit-serial ten's-complement BCD ALU and flight FSM in one block.

---
 rtl/ll_pkg.sv | 19 +
 rtl/ll_bcd_digit.sv | 27 ++
 rtl/ll_step_engine.sv | 217 +++++++++++++++++++++
 tb/tb_ll_step_engine.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/ll_pkg.sv
// Shared types and BCD helpers for the lunar-lander step engine.
package ll_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    CHECK,
    LANDED,
    CRASHED
  } ll_state_t;

  localparam logic [3:0] BCD_NINE = 4'h9;
  localparam logic [3:0] BCD_ZERO = 4'h0;

  function automatic logic [3:0] nines(input logic [3:0] d);
    return BCD_NINE - d;
  endfunction

endpackage

// File: rtl/ll_bcd_digit.sv
// One BCD digit of a ten's-complement adder/subtractor.
module ll_bcd_digit
  import ll_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       op,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [3:0] bb;
  logic [4:0] sum;

  always_comb begin
    bb  = op ? nines(b) : b;
    sum = {1'b0, a} + {1'b0, bb} + {4'b0, ci};
    s   = sum[3:0];
    co  = 1'b0;
    if (sum > 5'd9) begin
      s  = sum[3:0] + 4'h6;
      co = 1'b1;
    end
  end

endmodule

// File: rtl/ll_step_engine.sv
// Lunar-lander state engine: registers, digit-serial BCD datapath, flight FSM.
module ll_step_engine
  import ll_pkg::*;
#(
  parameter int                  DIGITS     = 4,
  parameter logic [4*DIGITS-1:0] ALTITUDE   = 'h4500,
  parameter logic [4*DIGITS-1:0] VELOCITY   = 'h0,
  parameter logic [4*DIGITS-1:0] FUEL       = 'h800,
  parameter logic [3:0]          THRUST     = 'h5,
  parameter logic [3:0]          GRAVITY    = 'h5,
  parameter logic [4*DIGITS-1:0] CRASH_VEL  = 'h30,
  parameter logic [3:0]          MAX_THRUST = 'h5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick,
  input  logic                  thrust_wr,
  input  logic [3:0]            thrust_in,
  output logic [4*DIGITS-1:0]   alt,
  output logic [4*DIGITS-1:0]   vel,
  output logic [4*DIGITS-1:0]   fuel,
  output logic [3:0]            thrust,
  output logic                  busy,
  output logic                  landed,
  output logic                  crashed,
  output logic                  tick_lost
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  function automatic logic [W-1:0] tens_comp(
    input logic [W-1:0] v
  );
    logic [W-1:0] r;
    logic [4:0]   t;
    logic         c;
    r = '0;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      t = {1'b0, nines(v[4*i +: 4])} + {4'b0, c};
      c = (t > 5'd9);
      if (c) t = t - 5'd10;
      r[4*i +: 4] = t[3:0];
    end
    return r;
  endfunction

  // Negative velocities at or below this code have |v| >= CRASH_VEL.
  localparam logic [W-1:0] CRASH_LIM = tens_comp(CRASH_VEL);

  ll_state_t state, state_n;

  logic [CW-1:0] cnt;
  logic [W-1:0]  alt_sh, vel_sh, fuel_sh;
  logic          alt_c, vel_c1, vel_c2, fuel_c;
  logic [3:0]    step_thr, thr_eff;
  logic [3:0]    pend_t;
  logic          pend_v;

  logic          wr_ok, last, first;
  logic [3:0]    step_sel;
  logic [3:0]    g_d, t_d;
  logic [3:0]    alt_s, vel_s1, vel_s2, fuel_s;
  logic          alt_co, vel_co1, vel_co2, fuel_co;
  logic [W-1:0]  fuel_n;
  logic          touch, crash, alt_neg, vel_neg;

  assign wr_ok    = thrust_wr && (thrust_in <= BCD_NINE);
  assign step_sel = wr_ok ? thrust_in : thrust;
  assign last     = (cnt == CW'(DIGITS - 1));
  assign first    = (cnt == '0);
  assign g_d      = first ? GRAVITY : BCD_ZERO;
  assign t_d      = first ? thr_eff : BCD_ZERO;

  ll_bcd_digit u_alt (
    .a  (alt_sh[3:0]),
    .b  (vel_sh[3:0]),
    .op (1'b0),
    .ci (alt_c),
    .s  (alt_s),
    .co (alt_co)
  );

  ll_bcd_digit u_vel_g (
    .a  (vel_sh[3:0]),
    .b  (g_d),
    .op (1'b1),
    .ci (vel_c1),
    .s  (vel_s1),
    .co (vel_co1)
  );

  ll_bcd_digit u_vel_t (
    .a  (vel_s1),
    .b  (t_d),
    .op (1'b0),
    .ci (vel_c2),
    .s  (vel_s2),
    .co (vel_co2)
  );

  ll_bcd_digit u_fuel (
    .a  (fuel_sh[3:0]),
    .b  (t_d),
    .op (1'b1),
    .ci (fuel_c),
    .s  (fuel_s),
    .co (fuel_co)
  );

  // A missing carry out of the fuel MSD means the subtraction borrowed.
  always_comb begin
    fuel_n  = fuel_c ? fuel_sh : '0;
    alt_neg = (alt_sh[W-1:W-4] >= 4'h5);
    vel_neg = (vel_sh[W-1:W-4] >= 4'h5);
    touch   = alt_neg || (alt_sh == '0);
    crash   = (vel_neg && (vel_sh <= CRASH_LIM))
           || (step_thr > MAX_THRUST);
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (tick) state_n = CALC;
      CALC:    if (last) state_n = CHECK;
      CHECK: begin
        unique case (1'b1)
          !touch:         state_n = IDLE;
          touch && crash: state_n = CRASHED;
          default:        state_n = LANDED;
        endcase
      end
      LANDED:  state_n = LANDED;
      CRASHED: state_n = CRASHED;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alt       <= ALTITUDE;
      vel       <= VELOCITY;
      fuel      <= FUEL;
      thrust    <= THRUST;
      tick_lost <= 1'b0;
      cnt       <= '0;
      alt_sh    <= '0;
      vel_sh    <= '0;
      fuel_sh   <= '0;
      alt_c     <= 1'b0;
      vel_c1    <= 1'b0;
      vel_c2    <= 1'b0;
      fuel_c    <= 1'b0;
      step_thr  <= '0;
      thr_eff   <= '0;
      pend_t    <= '0;
      pend_v    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (wr_ok) thrust <= thrust_in;
          if (tick) begin
            cnt      <= '0;
            alt_sh   <= alt;
            vel_sh   <= vel;
            fuel_sh  <= fuel;
            alt_c    <= 1'b0;
            vel_c1   <= 1'b1;
            vel_c2   <= 1'b0;
            fuel_c   <= 1'b1;
            step_thr <= step_sel;
            thr_eff  <= (fuel == '0) ? BCD_ZERO : step_sel;
          end
        end
        CALC: begin
          if (tick) tick_lost <= 1'b1;
          if (wr_ok) begin
            pend_t <= thrust_in;
            pend_v <= 1'b1;
          end
          // Result digits enter at the top as operand digits leave the bottom.
          cnt     <= cnt + 1'b1;
          alt_sh  <= {alt_s,  alt_sh[W-1:4]};
          vel_sh  <= {vel_s2, vel_sh[W-1:4]};
          fuel_sh <= {fuel_s, fuel_sh[W-1:4]};
          alt_c   <= alt_co;
          vel_c1  <= vel_co1;
          vel_c2  <= vel_co2;
          fuel_c  <= fuel_co;
        end
        CHECK: begin
          if (tick) tick_lost <= 1'b1;
          alt    <= touch ? '0 : alt_sh;
          vel    <= vel_sh;
          fuel   <= fuel_n;
          pend_v <= 1'b0;
          if (!touch) begin
            if (wr_ok)       thrust <= thrust_in;
            else if (pend_v) thrust <= pend_t;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state == CALC) || (state == CHECK);
  assign landed  = (state == LANDED);
  assign crashed = (state == CRASHED);

endmodule

// File: tb/tb_ll_step_engine.sv
// Directed bench for ll_step_engine across several reset configurations.
module tb_ll_step_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  tick = '0;
  logic [4:0]  twr = '0;
  logic [3:0]  thrust_in = '0;
  logic [15:0] alt_o [5];
  logic [15:0] vel_o [5];
  logic [15:0] fuel_o [5];
  logic [3:0]  thr_o [5];
  logic [4:0]  busy, landed, crashed, lost;

  int total = 0;
  int bad = 0;
  int cyc;

  always #5 clk = ~clk;

  ll_step_engine u0 (
    .clk(clk), .rst_n(rst_n), .tick(tick[0]),
    .thrust_wr(twr[0]), .thrust_in(thrust_in),
    .alt(alt_o[0]), .vel(vel_o[0]), .fuel(fuel_o[0]),
    .thrust(thr_o[0]), .busy(busy[0]), .landed(landed[0]),
    .crashed(crashed[0]), .tick_lost(lost[0])
  );

  ll_step_engine #(.FUEL(16'h0003)) u1 (
    .clk(clk), .rst_n(rst_n), .tick(tick[1]),
    .thrust_wr(twr[1]), .thrust_in(thrust_in),
    .alt(alt_o[1]), .vel(vel_o[1]), .fuel(fuel_o[1]),
    .thrust(thr_o[1]), .busy(busy[1]), .landed(landed[1]),
    .crashed(crashed[1]), .tick_lost(lost[1])
  );

  ll_step_engine #(.ALTITUDE(16'h0010), .VELOCITY(16'h9980)) u2 (
    .clk(clk), .rst_n(rst_n), .tick(tick[2]),
    .thrust_wr(twr[2]), .thrust_in(thrust_in),
    .alt(alt_o[2]), .vel(vel_o[2]), .fuel(fuel_o[2]),
    .thrust(thr_o[2]), .busy(busy[2]), .landed(landed[2]),
    .crashed(crashed[2]), .tick_lost(lost[2])
  );

  ll_step_engine #(.ALTITUDE(16'h0010), .VELOCITY(16'h9960)) u3 (
    .clk(clk), .rst_n(rst_n), .tick(tick[3]),
    .thrust_wr(twr[3]), .thrust_in(thrust_in),
    .alt(alt_o[3]), .vel(vel_o[3]), .fuel(fuel_o[3]),
    .thrust(thr_o[3]), .busy(busy[3]), .landed(landed[3]),
    .crashed(crashed[3]), .tick_lost(lost[3])
  );

  ll_step_engine #(.ALTITUDE(16'h0010), .VELOCITY(16'h9980),
                   .THRUST(4'h6)) u4 (
    .clk(clk), .rst_n(rst_n), .tick(tick[4]),
    .thrust_wr(twr[4]), .thrust_in(thrust_in),
    .alt(alt_o[4]), .vel(vel_o[4]), .fuel(fuel_o[4]),
    .thrust(thr_o[4]), .busy(busy[4]), .landed(landed[4]),
    .crashed(crashed[4]), .tick_lost(lost[4])
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_step(input int i, output int n);
    @(negedge clk);
    tick[i] = 1'b1;
    @(negedge clk);
    tick[i] = 1'b0;
    n = 0;
    while (busy[i] && n < 20) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic write_thr(input int i, input logic [3:0] v);
    @(negedge clk);
    twr[i] = 1'b1;
    thrust_in = v;
    @(negedge clk);
    twr[i] = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_alt", 32'(alt_o[0]), 32'h4500);
    chk("rst_vel", 32'(vel_o[0]), 32'h0000);
    chk("rst_fuel", 32'(fuel_o[0]), 32'h0800);
    chk("rst_thr", 32'(thr_o[0]), 32'h5);
    chk("rst_flags", 32'({busy[0], landed[0], crashed[0], lost[0]}), 32'h0);

    do_step(0, cyc);
    chk("idle_busy_cycles", 32'(cyc), 32'd5);
    chk("idle_alt", 32'(alt_o[0]), 32'h4500);
    chk("idle_vel", 32'(vel_o[0]), 32'h0000);
    chk("idle_fuel", 32'(fuel_o[0]), 32'h0795);

    write_thr(0, 4'hA);
    chk("thr_invalid_ignored", 32'(thr_o[0]), 32'h5);

    do_reset();
    write_thr(0, 4'h0);
    chk("thr0_written", 32'(thr_o[0]), 32'h0);
    do_step(0, cyc);
    chk("thr0_s1_vel", 32'(vel_o[0]), 32'h9995);
    chk("thr0_s1_alt", 32'(alt_o[0]), 32'h4500);
    do_step(0, cyc);
    chk("thr0_s2_vel", 32'(vel_o[0]), 32'h9990);
    chk("thr0_s2_alt", 32'(alt_o[0]), 32'h4495);
    chk("thr0_s2_fuel", 32'(fuel_o[0]), 32'h0800);

    do_reset();
    do_step(1, cyc);
    chk("fuel_sat_fuel", 32'(fuel_o[1]), 32'h0000);
    chk("fuel_sat_vel", 32'(vel_o[1]), 32'h0000);
    do_step(1, cyc);
    chk("fuel_out_vel", 32'(vel_o[1]), 32'h9995);
    chk("fuel_out_fuel", 32'(fuel_o[1]), 32'h0000);
    chk("fuel_out_alt", 32'(alt_o[1]), 32'h4500);

    do_step(2, cyc);
    chk("soft_alt", 32'(alt_o[2]), 32'h0000);
    chk("soft_vel", 32'(vel_o[2]), 32'h9980);
    chk("soft_fuel", 32'(fuel_o[2]), 32'h0795);
    chk("soft_flags", 32'({busy[2], landed[2], crashed[2]}), 32'b010);
    write_thr(2, 4'h2);
    do_step(2, cyc);
    chk("landed_thr_frozen", 32'(thr_o[2]), 32'h5);
    chk("landed_vel_frozen", 32'(vel_o[2]), 32'h9980);
    chk("landed_fuel_frozen", 32'(fuel_o[2]), 32'h0795);
    chk("landed_no_lost", 32'({landed[2], lost[2]}), 32'b10);

    do_step(3, cyc);
    chk("crash_vel_flags", 32'({landed[3], crashed[3]}), 32'b01);
    chk("crash_vel_alt", 32'(alt_o[3]), 32'h0000);
    chk("crash_vel_vel", 32'(vel_o[3]), 32'h9960);

    do_step(4, cyc);
    chk("crash_thr_flags", 32'({landed[4], crashed[4]}), 32'b01);
    chk("crash_thr_vel", 32'(vel_o[4]), 32'h9981);
    chk("crash_thr_fuel", 32'(fuel_o[4]), 32'h0794);

    do_reset();
    @(negedge clk);
    tick[0] = 1'b1;
    @(negedge clk);
    tick[0] = 1'b0;
    @(negedge clk);
    tick[0] = 1'b1;
    @(negedge clk);
    tick[0] = 1'b0;
    twr[0] = 1'b1;
    thrust_in = 4'h7;
    @(negedge clk);
    twr[0] = 1'b0;
    chk("pend_thr_held", 32'(thr_o[0]), 32'h5);
    cyc = 0;
    while (busy[0] && cyc < 20) begin
      cyc++;
      @(negedge clk);
    end
    chk("hs_finished", 32'(busy[0]), 32'h0);
    chk("hs_tick_lost", 32'(lost[0]), 32'h1);
    chk("hs_thr_applied", 32'(thr_o[0]), 32'h7);
    chk("hs_one_step_fuel", 32'(fuel_o[0]), 32'h0795);
    chk("hs_vel", 32'(vel_o[0]), 32'h0000);

    write_thr(0, 4'h0);
    do_step(0, cyc);
    chk("pre_abort_vel", 32'(vel_o[0]), 32'h9995);
    @(negedge clk);
    tick[0] = 1'b1;
    @(negedge clk);
    tick[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", 32'(busy[0]), 32'h0);
    chk("abort_vel", 32'(vel_o[0]), 32'h0000);
    chk("abort_fuel", 32'(fuel_o[0]), 32'h0800);
    chk("abort_thr", 32'(thr_o[0]), 32'h5);
    chk("abort_lost", 32'(lost[0]), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
